// File: rtl/eth_tx_stats_gen.sv
// Passive AXI-Stream TX monitor: parses each frame and emits a TEMAC-style
// per-frame statistics vector with a one-cycle valid pulse.
module eth_tx_stats_gen #(
  parameter bit add_fcs   = 1'b1,
  parameter bit pad_short = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [31:0] tx_stats_vector,
  output logic        tx_stats_valid
);

  typedef enum logic [1:0] {IDLE, FRAME, DRAIN} state_t;

  state_t      state;
  logic [15:0] count;
  logic        bc_all_ff, dst_lsb, underrun;
  logic [7:0]  b12, b13, b14, b15;

  logic        beat;
  logic [15:0] idx, n_count;
  logic        n_bc, n_lsb, n_ur;
  logic [7:0]  n_b12, n_b13, n_b14, n_b15;
  logic        r_bc, r_mc, r_vlan, r_ctl, r_pause, r_good;
  logic [15:0] ethertype;
  logic [16:0] len;
  logic [13:0] len14;
  logic [31:0] report;

  assign beat = s_axis_tvalid & s_axis_tready;

  // Parse state as it stands after the current beat, so a tlast beat reports
  // including its own byte. A first beat in IDLE starts from a clean slate.
  always_comb begin
    idx     = (state == IDLE) ? 16'd0 : count;
    n_count = idx;
    n_bc    = (state == IDLE) ? 1'b1 : bc_all_ff;
    n_lsb   = (state == IDLE) ? 1'b0 : dst_lsb;
    n_ur    = (state == IDLE) ? 1'b0 : underrun;
    n_b12   = (state == IDLE) ? 8'd0 : b12;
    n_b13   = (state == IDLE) ? 8'd0 : b13;
    n_b14   = (state == IDLE) ? 8'd0 : b14;
    n_b15   = (state == IDLE) ? 8'd0 : b15;
    if (beat && state != DRAIN) begin
      n_count = (idx == 16'hFFFF) ? idx : idx + 16'd1;
      case (idx)
        16'd0: begin
          n_lsb = s_axis_tdata[0];
          n_bc  = (s_axis_tdata == 8'hFF);
        end
        16'd1, 16'd2, 16'd3, 16'd4, 16'd5: n_bc = n_bc & (s_axis_tdata == 8'hFF);
        16'd12: n_b12 = s_axis_tdata;
        16'd13: n_b13 = s_axis_tdata;
        16'd14: n_b14 = s_axis_tdata;
        16'd15: n_b15 = s_axis_tdata;
        default: ;
      endcase
    end
  end

  // Flags whose bytes never arrived read as 0.
  always_comb begin
    ethertype = {n_b12, n_b13};
    r_bc      = n_bc && (n_count >= 16'd6);
    r_mc      = n_lsb && !r_bc;
    r_vlan    = (n_count >= 16'd14) && (ethertype == 16'h8100);
    r_ctl     = (n_count >= 16'd14) && (ethertype == 16'h8808);
    r_pause   = r_ctl && (n_count >= 16'd16) && ({n_b14, n_b15} == 16'h0001);
    r_good    = !n_ur && !s_axis_tuser;
    len       = {1'b0, n_count};
    if (pad_short && len < 17'd60) len = 17'd60;
    if (add_fcs) len = len + 17'd4;
    len14     = (len > 17'd16383) ? 14'h3FFF : len[13:0];
    report    = {11'd0, r_pause, r_vlan, len14, r_ctl, n_ur, r_mc, r_bc, r_good};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      bc_all_ff       <= 1'b0;
      dst_lsb         <= 1'b0;
      underrun        <= 1'b0;
      b12             <= '0;
      b13             <= '0;
      b14             <= '0;
      b15             <= '0;
      tx_stats_vector <= '0;
      tx_stats_valid  <= 1'b0;
    end else begin
      tx_stats_valid <= 1'b0;
      if (beat) begin
        count     <= n_count;
        bc_all_ff <= n_bc;
        dst_lsb   <= n_lsb;
        underrun  <= n_ur;
        b12       <= n_b12;
        b13       <= n_b13;
        b14       <= n_b14;
        b15       <= n_b15;
      end
      case (state)
        IDLE: if (beat) begin
          if (s_axis_tlast) begin
            tx_stats_vector <= report;
            tx_stats_valid  <= 1'b1;
          end else begin
            state <= FRAME;
          end
        end
        FRAME: begin
          if (beat && s_axis_tlast) begin
            tx_stats_vector <= report;
            tx_stats_valid  <= 1'b1;
            state           <= IDLE;
          end else if (s_axis_tready && !s_axis_tvalid) begin
            underrun <= 1'b1;
            state    <= DRAIN;
          end
        end
        DRAIN: if (beat && s_axis_tlast) begin
          tx_stats_vector <= report;
          tx_stats_valid  <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_stats_gen.sv
// Random + directed frames against a frame-level reference model; two DUTs
// cover both parameter settings from the same stream.
module tb_eth_tx_stats_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser;
  logic [31:0] vec_a, vec_b;
  logic        vld_a, vld_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fr[$];
  logic [7:0]  bq[$];
  logic [31:0] exp_a[$], exp_b[$];
  bit          in_fr, ur;

  always #5 clk = ~clk;

  eth_tx_stats_gen #(.add_fcs(1'b1), .pad_short(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .tx_stats_vector(vec_a), .tx_stats_valid(vld_a));

  eth_tx_stats_gen #(.add_fcs(1'b0), .pad_short(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .tx_stats_vector(vec_b), .tx_stats_valid(vld_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected vector straight from the frame's captured bytes.
  function automatic logic [31:0] mv(input bit fcs, input bit pad, input bit tu);
    int n = bq.size();
    bit bc, mc, vl, ct, ps;
    logic [15:0] et = 16'h0;
    int len;
    bc = (n >= 6);
    for (int i = 0; i < 6 && i < n; i++) if (bq[i] != 8'hFF) bc = 0;
    mc = bq[0][0] && !bc;
    if (n >= 14) et = {bq[12], bq[13]};
    vl = (n >= 14) && et == 16'h8100;
    ct = (n >= 14) && et == 16'h8808;
    ps = 0;
    if (ct && n >= 16) ps = ({bq[14], bq[15]} == 16'h0001);
    len = n;
    if (pad && len < 60) len = 60;
    if (fcs) len += 4;
    if (len > 16383) len = 16383;
    return {11'd0, ps, vl, 14'(len), ct, ur, mc, bc, !ur && !tu};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      in_fr = 0; ur = 0; bq.delete();
    end else if (tvalid && tready) begin
      if (!in_fr) begin bq.delete(); ur = 0; in_fr = 1; end
      if (!ur) bq.push_back(tdata);
      if (tlast) begin
        exp_a.push_back(mv(1, 1, tuser));
        exp_b.push_back(mv(0, 0, tuser));
        in_fr = 0;
      end
    end else if (in_fr && tready && !tvalid) begin
      ur = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_vec_a", vec_a, 32'h0);
      chk("rst_vld_a", {31'd0, vld_a}, 32'h0);
      chk("rst_vec_b", vec_b, 32'h0);
      chk("rst_vld_b", {31'd0, vld_b}, 32'h0);
    end else begin
      if (vld_a) begin
        if (exp_a.size() == 0) chk("spurious_a", vec_a, 32'hDEAD_0000);
        else chk("vec_a", vec_a, exp_a.pop_front());
      end
      if (vld_b) begin
        if (exp_b.size() == 0) chk("spurious_b", vec_b, 32'hDEAD_0000);
        else chk("vec_b", vec_b, exp_b.pop_front());
      end
    end
  end

  task automatic put(input int i, input logic [7:0] v);
    if (i < fr.size()) fr[i] = v;
  endtask

  // kind: 0 unicast/IPv4, 1 broadcast, 2 pause, 3 VLAN, 4 raw random
  task automatic build(input int n, input int kind);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    case (kind)
      0: begin put(0, 8'h02); put(12, 8'h08); put(13, 8'h00); end
      1: begin
        for (int i = 0; i < 6; i++) put(i, 8'hFF);
        put(12, 8'h08); put(13, 8'h00);
      end
      2: begin
        put(0, 8'h01); put(1, 8'h80); put(2, 8'hC2); put(3, 8'h00); put(4, 8'h00); put(5, 8'h01);
        put(12, 8'h88); put(13, 8'h08); put(14, 8'h00); put(15, 8'h01);
      end
      3: begin put(12, 8'h81); put(13, 8'h00); end
      default: ;
    endcase
  endtask

  task automatic send(input bit tu, input int ur_at, input bit gaps);
    int n = fr.size();
    for (int i = 0; i < n; i++) begin
      if (ur_at != 0 && i == ur_at) begin
        tvalid = 0; tready = 1; tlast = 0; tdata = 8'($urandom);
        @(posedge clk); #1;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        tready = 0; tvalid = 1'($urandom); tdata = 8'($urandom); tlast = 1'($urandom);
        @(posedge clk); #1;
      end
      tready = 1; tvalid = 1; tdata = fr[i]; tlast = (i == n - 1);
      tuser = (i == n - 1) ? tu : 1'($urandom);
      @(posedge clk); #1;
    end
    tvalid = 0; tlast = 0; tuser = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tvalid = 0; tready = 1'($urandom); tdata = 8'($urandom);
      tlast = 1'($urandom); tuser = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 0; tvalid = 0; tready = 0; tdata = 0; tlast = 0; tuser = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);

    build(64, 0); send(0, 0, 1); idle(3);
    chk("tp_unicast", vec_a, 32'h0000_0881);
    build(14, 1); send(0, 0, 0); idle(3);
    chk("tp_bcast", vec_a, 32'h0000_0803);
    build(60, 2); send(0, 0, 1); idle(3);
    chk("tp_pause", vec_a, 32'h0010_0815);
    build(30, 0); send(0, 20, 0); idle(3);
    chk("tp_underrun", vec_a, 32'h0000_0808);
    chk("tp_underrun_b", vec_b, 32'h0000_0288);

    build(100, 3); send(0, 0, 0);
    build(70, 0);  send(1, 0, 0); idle(3);
    chk("tp_b2b_b", vec_b, 32'h0000_08C0);

    build(1, 4); send(0, 0, 0);
    build(1, 1); send(1, 0, 0); idle(3);

    // Abort a frame mid-flight with reset; no report may come from it.
    build(40, 0);
    for (int i = 0; i < 30; i++) begin
      tvalid = 1; tready = 1; tdata = fr[i]; tlast = 0; tuser = 0;
      @(posedge clk); #1;
    end
    rst_n = 0;
    idle(3);
    rst_n = 1;
    idle(2);
    build(60, 0); send(0, 0, 0); idle(3);
    chk("tp_after_rst", vec_a, 32'h0000_0801);

    build(16390, 0); send(0, 0, 0); idle(3);
    chk("tp_sat_a", vec_a, 32'h0007_FFE1);
    chk("tp_sat_b", vec_b, 32'h0007_FFE1);

    for (int f = 0; f < 250; f++) begin
      int n = $urandom_range(1, 80);
      int ua = 0;
      build(n, $urandom_range(0, 4));
      if (n >= 2 && $urandom_range(0, 5) == 0) ua = $urandom_range(1, n - 1);
      send(1'($urandom_range(0, 3) == 0), ua, 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
    end

    idle(5);
    chk("pending_a", 32'(exp_a.size()), 32'd0);
    chk("pending_b", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_stats_gen.md
Name: eth_tx_stats_gen

Overview:
- Passive monitor on an 8-bit AXI-Stream transmit path feeding a MAC.
- Parses each frame and emits a TEMAC-format tx_stats_vector / tx_stats_valid pulse per frame.
- Acts as the producer side of the TX statistics interface consumed by eth_stats_collector; used where no hard TEMAC supplies statistics (custom MAC, loopback, simulation).

Parameters:
- add_fcs, 1, when 1 the reported length includes 4 FCS bytes appended by the MAC.
- pad_short, 1, when 1 the reported length before FCS is raised to a minimum of 60 (MAC padding).

Ports:
- clk  input  1  single clock for stream and stats outputs.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  8  monitored frame byte.
- s_axis_tvalid  input  1  monitored valid.
- s_axis_tready  input  1  monitored ready; the block never drives the stream.
- s_axis_tlast  input  1  last byte of frame.
- s_axis_tuser  input  1  error marker, sampled on the tlast beat.
- tx_stats_vector  output  32  per-frame statistics, held until the next frame report.
- tx_stats_valid  output  1  one-cycle pulse marking a new tx_stats_vector.

Behaviour:
- Beat: cycle with tvalid & tready. All parsing occurs on beats only.
- Reset: tx_stats_vector = 0, tx_stats_valid = 0, state IDLE, all counters and flags cleared. Async assert; a frame in flight at reset is discarded with no report.
- States and transitions:
  - IDLE: first beat starts a frame at byte index 0 and moves to FRAME. A one-byte frame (tlast on the first beat) reports immediately and stays in IDLE.
  - FRAME: counts beats. A cycle with tready=1 & tvalid=0 is an underrun: set underrun, freeze the byte count, move to DRAIN. A tlast beat reports and returns to IDLE.
  - DRAIN: ignores data and counting until a tlast beat, then reports and returns to IDLE.
- Byte count: internal 16-bit counter. Reported length = count, raised to 60 if pad_short, plus 4 if add_fcs. Saturate at 16383 (14-bit field).
- Header parse (byte indices):
  - Broadcast: bytes 0-5 all 0xFF.
  - Multicast: byte0 bit0 = 1 and not broadcast.
  - Ethertype: bytes 12-13. 0x8100 sets VLAN; 0x8808 sets control.
  - Pause: control and bytes 14-15 = 0x0001.
  - A flag whose bytes were never fully received reports 0 (runt frames).
- Vector layout:
  - bit0 good = not underrun and not tuser-on-tlast.
  - bit1 broadcast; bit2 multicast; bit3 underrun; bit4 control.
  - bits18:5 length; bit19 VLAN; bit20 pause.
  - bits31:21 = 0.
  - Parse flags are reported even when good=0.
- Latency: tx_stats_vector and tx_stats_valid are registered and update on the clock edge after the tlast beat. Valid is high exactly 1 cycle.
- Back-to-back frames: a beat in the cycle right after tlast starts a new frame. Its parse state is cleared on that first beat, independent of the pending report pulse. Reports never merge or drop.
- tready low: the cycle is not a beat and not an underrun; the block simply waits.
- tvalid=0 in IDLE is ignored.
- tuser on a non-last beat is ignored.

Test Plan:
- 64-byte unicast frame (byte0 = 0x02, ethertype 0x0800), add_fcs=1, pad_short=1 -> one pulse 1 cycle after tlast. Vector: good=1, length=68, bits 1-4 and 19-20 = 0 (vector 0x00000881).
- 14-byte broadcast frame, all dest bytes 0xFF, ethertype 0x0800 -> length 64, broadcast=1, multicast=0, good=1 (vector 0x00000803).
- Pause frame: dest 01-80-C2-00-00-01, ethertype 0x8808, opcode 0x0001, 60 bytes -> multicast=1, control=1, pause=1, length=64 (vector 0x00100815).
- Underrun: tvalid drops after 20 beats while tready=1, then 10 more beats ending in tlast -> good=0, underrun=1, length=64 (padded 20 -> 60, +4). Pulse follows the final tlast beat.
- Back-to-back: frame A (100 bytes, VLAN 0x8100) tlast immediately followed by frame B (70 bytes, tuser=1 on tlast), add_fcs=0 -> two distinct pulses. A: length=100, VLAN=1, good=1. B: length=70, good=0, VLAN=0.
- rst_n asserted mid-frame at byte 30, then released and a 60-byte frame sent -> no report for the aborted frame. Outputs read 0 during reset. Exactly one report (length=64) for the new frame.
